nec_cmd_sink: RTL and testbench

Consumer for the 32-bit NEC frames produced by the IR receiver (the data_ready / data_out pair). It validates the NEC inverse fields, drops corrupt frames, and flags held-key repeats using a timing window. Accepted commands are queued in a small show-ahead FIFO with a valid/ready handshake for downstream control logic such as a menu or LED controller. Error and drop counters are exposed for the HEX/LEDR debug display.

---
 rtl/nec_pkg.sv | 21 ++
 rtl/nec_cmd_fifo.sv | 55 +++++
 rtl/nec_cmd_sink.sv | 166 ++++++++++++++++
 tb/tb_nec_cmd_sink.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nec_pkg.sv
// Shared types and frame field positions for the NEC command sink.
package nec_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_PUSH
    } state_e;

    localparam int unsigned ADDR_LSB  = 0;
    localparam int unsigned IADDR_LSB = 8;
    localparam int unsigned CMD_LSB   = 16;
    localparam int unsigned ICMD_LSB  = 24;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  cmd;
        logic        rpt;
    } cmd_entry_t;

endpackage

// File: rtl/nec_cmd_fifo.sv
// Show-ahead synchronous FIFO for decoded NEC command entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module nec_cmd_fifo
    import nec_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  cmd_entry_t               wdata,
    input  logic                     pop,
    output cmd_entry_t               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    cmd_entry_t  mem [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written.
    assign do_push = push && (!full || pop);
    assign rdata   = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nec_cmd_sink.sv
// Validates NEC frames, tags held-key repeats and queues commands for downstream logic.
// Define NEC_EXT_ADDR_EN for extended 16-bit addressing (address inverse not checked).
module nec_cmd_sink
    import nec_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned REPEAT_WINDOW = 6000000,
    parameter int unsigned CNT_W         = 8
) (
    input  logic              iCLK_50,
    input  logic              iRST_n,
    input  logic              iDATA_READY,
    input  logic [31:0]       iDATA,
    output logic              oCMD_VALID,
    input  logic              iCMD_READY,
    output logic [15:0]       oCMD_ADDR,
    output logic [7:0]        oCMD,
    output logic              oCMD_REPEAT,
    output logic              oFIFO_FULL,
    output logic [CNT_W-1:0]  oERR_CNT,
    output logic [CNT_W-1:0]  oDROP_CNT
);

    localparam int unsigned WIN_W = (REPEAT_WINDOW > 1) ? $clog2(REPEAT_WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_RELOAD = WIN_W'(REPEAT_WINDOW - 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    logic             ready_q;
    logic             edge_det;
    state_e           state_q;
    state_e           state_d;
    logic             latch_frame;
    logic             check_cycle;
    logic             push_cycle;
    logic [31:0]      frame_q;
    logic [31:0]      last_frame_q;
    logic             ok_c;
    logic             ok_q;
    logic [WIN_W-1:0] window_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W:0]   drop_sum;
    logic             accept;
    logic             can_push;
    logic             drop_full;
    logic             drop_busy;
    logic             pop;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;
    cmd_entry_t       wr_entry;
    cmd_entry_t       head;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    always_ff @(posedge iCLK_50 or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= iDATA_READY;
        end
    end
    assign edge_det = iDATA_READY && !ready_q;

    always_ff @(posedge iCLK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (edge_det) state_d = S_CHECK;
            S_CHECK: state_d = S_PUSH;
            S_PUSH:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        latch_frame = (state_q == S_IDLE) && edge_det;
        check_cycle = (state_q == S_CHECK);
        push_cycle  = (state_q == S_PUSH);
    end

`ifdef NEC_EXT_ADDR_EN
    assign ok_c = (frame_q[CMD_LSB +: 8] == ~frame_q[ICMD_LSB +: 8]);
    assign wr_entry.addr = frame_q[ADDR_LSB +: 16];
`else
    assign ok_c = (frame_q[CMD_LSB +: 8] == ~frame_q[ICMD_LSB +: 8])
               && (frame_q[ADDR_LSB +: 8] == ~frame_q[IADDR_LSB +: 8]);
    assign wr_entry.addr = {8'h00, frame_q[ADDR_LSB +: 8]};
`endif
    assign wr_entry.cmd = frame_q[CMD_LSB +: 8];
    assign wr_entry.rpt = (frame_q == last_frame_q) && (window_q != '0);

    assign pop       = !fifo_empty && iCMD_READY;
    assign can_push  = (fifo_count != FCW'(FIFO_DEPTH)) || pop;
    assign accept    = push_cycle && ok_q;
    assign fifo_push = accept && can_push;
    assign drop_full = accept && !can_push;
    assign drop_busy = edge_det && (state_q != S_IDLE);
    assign drop_sum  = {1'b0, drop_cnt_q} + (CNT_W + 1)'(drop_full) + (CNT_W + 1)'(drop_busy);

    always_ff @(posedge iCLK_50 or negedge rst_n) begin
        if (!rst_n) begin
            frame_q      <= '0;
            ok_q         <= 1'b0;
            last_frame_q <= '0;
            window_q     <= '0;
            err_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (latch_frame) frame_q <= iDATA;
            if (check_cycle) ok_q <= ok_c;
            if (accept) begin
                last_frame_q <= frame_q;
                window_q     <= WIN_RELOAD;
            end else if (window_q != '0) begin
                window_q <= window_q - 1'b1;
            end
            if (push_cycle && !ok_q && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            drop_cnt_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    nec_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iCLK_50),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head fields are gated so stale storage never shows while the queue is empty.
    assign oCMD_VALID  = !fifo_empty;
    assign oCMD_ADDR   = fifo_empty ? 16'h0000 : head.addr;
    assign oCMD        = fifo_empty ? 8'h00 : head.cmd;
    assign oCMD_REPEAT = !fifo_empty && head.rpt;
    assign oFIFO_FULL  = fifo_full;
    assign oERR_CNT    = err_cnt_q;
    assign oDROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_nec_cmd_sink.sv
// Directed bench for nec_cmd_sink; expectations follow NEC_EXT_ADDR_EN when defined.
module tb_nec_cmd_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_ready;
    logic [31:0] data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd;
    logic        cmd_repeat;
    logic        fifo_full;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nec_cmd_sink #(
        .FIFO_DEPTH    (4),
        .REPEAT_WINDOW (100),
        .CNT_W         (8)
    ) dut (
        .iCLK_50     (clk),
        .iRST_n      (rst_n),
        .iDATA_READY (data_ready),
        .iDATA       (data),
        .oCMD_VALID  (cmd_valid),
        .iCMD_READY  (cmd_ready),
        .oCMD_ADDR   (cmd_addr),
        .oCMD        (cmd),
        .oCMD_REPEAT (cmd_repeat),
        .oFIFO_FULL  (fifo_full),
        .oERR_CNT    (err_cnt),
        .oDROP_CNT   (drop_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] make_frame(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    function automatic logic [15:0] exp_addr(input logic [31:0] f);
`ifdef NEC_EXT_ADDR_EN
        return f[15:0];
`else
        return {8'h00, f[7:0]};
`endif
    endfunction

    // One-cycle frame-ready pulse; returns once the entry would be visible.
    task automatic send_frame(input logic [31:0] f);
        data       = f;
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        tick(2);
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] f;
        rst_n      = 1'b0;
        data_ready = 1'b0;
        data       = '0;
        cmd_ready  = 1'b0;
        tick(3);
        check_eq("rst_valid", cmd_valid, 0);
        check_eq("rst_full", fifo_full, 0);
        check_eq("rst_err", err_cnt, 0);
        check_eq("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick(4);

        // 1: latency and head fields
        data       = 32'hE51AFE01;
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check_eq("t1_lat1", cmd_valid, 0);
        tick();
        check_eq("t1_lat2", cmd_valid, 0);
        tick();
        check_eq("t1_lat3", cmd_valid, 1);
        check_eq("t1_addr", cmd_addr, 16'h0001);
        check_eq("t1_cmd", cmd, 8'h1A);
        check_eq("t1_rpt", cmd_repeat, 0);
        pop_one();
        check_eq("t1_popped", cmd_valid, 0);

        // 2: corrupt frame counted, following good frame not a repeat
        tick(150);
        send_frame(32'hE51BFE01);
        tick();
        check_eq("t2_err", err_cnt, 1);
        check_eq("t2_valid", cmd_valid, 0);
        send_frame(32'hE51AFE01);
        check_eq("t2_good_valid", cmd_valid, 1);
        check_eq("t2_good_rpt", cmd_repeat, 0);
        pop_one();

        // 3: repeat window
        tick(150);
        send_frame(32'hE51AFE01);
        check_eq("t3_rpt0", cmd_repeat, 0);
        pop_one();
        tick(46);
        send_frame(32'hE51AFE01);
        check_eq("t3_valid1", cmd_valid, 1);
        check_eq("t3_rpt1", cmd_repeat, 1);
        pop_one();
        tick(200);
        send_frame(32'hE51AFE01);
        check_eq("t3_rpt2", cmd_repeat, 0);
        pop_one();

        // 4: fill the queue, drop the fifth, drain in order
        tick(150);
        for (int i = 0; i < 5; i++) begin
            send_frame(make_frame(8'h40 + 8'(i), 8'h10 + 8'(i)));
            if (i == 2) check_eq("t4_not_full", fifo_full, 0);
            if (i == 3) check_eq("t4_full", fifo_full, 1);
        end
        check_eq("t4_drop", drop_cnt, 1);
        check_eq("t4_err", err_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            f = make_frame(8'h40 + 8'(i), 8'h10 + 8'(i));
            check_eq($sformatf("t4_valid%0d", i), cmd_valid, 1);
            check_eq($sformatf("t4_cmd%0d", i), cmd, f[23:16]);
            check_eq($sformatf("t4_addr%0d", i), cmd_addr, exp_addr(f));
            check_eq($sformatf("t4_rpt%0d", i), cmd_repeat, 0);
            pop_one();
        end
        check_eq("t4_empty", cmd_valid, 0);
        check_eq("t4_full_clr", fifo_full, 0);

        // 5: held level gives one event; reset mid-check clears everything
        data       = 32'hE51AFE01;
        data_ready = 1'b1;
        tick(1000);
        data_ready = 1'b0;
        tick();
        check_eq("t5_one_valid", cmd_valid, 1);
        check_eq("t5_one_cmd", cmd, 8'h1A);
        pop_one();
        check_eq("t5_one_only", cmd_valid, 0);
        check_eq("t5_drop_same", drop_cnt, 1);
        send_frame(make_frame(8'h55, 8'h66));
        data       = make_frame(8'h22, 8'h33);
        data_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", cmd_valid, 0);
        check_eq("t5_rst_addr", cmd_addr, 0);
        check_eq("t5_rst_cmd", cmd, 0);
        check_eq("t5_rst_rpt", cmd_repeat, 0);
        check_eq("t5_rst_full", fifo_full, 0);
        check_eq("t5_rst_err", err_cnt, 0);
        check_eq("t5_rst_drop", drop_cnt, 0);
        data_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check_eq("t5_post_valid", cmd_valid, 0);
        check_eq("t5_post_err", err_cnt, 0);

        // 6: extended-address frame
        send_frame(32'hE51A3412);
        tick();
`ifdef NEC_EXT_ADDR_EN
        check_eq("t6_valid", cmd_valid, 1);
        check_eq("t6_addr", cmd_addr, 16'h3412);
        check_eq("t6_cmd", cmd, 8'h1A);
        check_eq("t6_err", err_cnt, 0);
`else
        check_eq("t6_valid", cmd_valid, 0);
        check_eq("t6_err", err_cnt, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
